// File: rtl/vfm_icl_rx.sv
// Inter-core link receiver: registers peer req/data, runs the 4-phase req/ack handshake, queues words in a FWFT FIFO.
// Latency: word visible on rd_data and ack raised two edges after req rises; ack falls two edges after req falls.
// Backpressure: while the FIFO is full the ack is withheld (no data loss) until a pop frees an entry.
module vfm_icl_rx #(
    parameter int DATA_W = 14,
    parameter int DEPTH  = 4,
    parameter int AW     = 2
) (
    input  logic              Clock_pin,
    input  logic              Resetn_pin,
    input  logic [DATA_W-1:0] link_req_in,
    input  logic [DATA_W-1:0] link_data_in,
    output logic [DATA_W-1:0] link_ack_out,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [AW:0]       count,
    output logic [15:0]       rx_total,
    output logic              proto_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t            state;
    logic              req_q;
    logic [DATA_W-1:0] data_q;
    logic              ack_bit;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     last_ptr;

    logic              push;
    logic              pop;
    logic              req_hi_unused;

    // Only bit 0 of the request word carries the handshake.
    assign req_hi_unused = ^link_req_in[DATA_W-1:1];

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    // Push and pop eligibility both use the flags as they stand before the edge.
    assign push     = (state == ST_IDLE) && req_q && !full;
    assign pop      = rd_en && !empty;
    // Slot holding the word of the current handshake (no push can happen while in ACK).
    assign last_ptr = wr_ptr - AW'(1);

    assign link_ack_out = {{(DATA_W-1){1'b0}}, ack_bit};
    assign rd_data      = empty ? '0 : mem[rd_ptr];

    // Register the peer request bit and data word; all decisions use these copies.
    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            req_q  <= 1'b0;
            data_q <= '0;
        end else begin
            req_q  <= link_req_in[0];
            data_q <= link_data_in;
        end
    end

    // Handshake FSM with registered ack and sticky data-stability error.
    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            state     <= ST_IDLE;
            ack_bit   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (push) begin
                        state   <= ST_ACK;
                        ack_bit <= 1'b1;
                    end
                end
                ST_ACK: begin
                    if (!req_q) begin
                        state   <= ST_IDLE;
                        ack_bit <= 1'b0;
                    end else if (data_q != mem[last_ptr]) begin
                        // Peer changed data while still requesting; captured word is kept.
                        proto_err <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    ack_bit <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers, occupancy and accepted-word counter.
    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rx_total <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + AW'(1);
                rx_total <= rx_total + 16'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care after reset since count gates every read.
    always_ff @(posedge Clock_pin) begin
        if (push) begin
            mem[wr_ptr] <= data_q;
        end
    end

endmodule

// File: tb/tb_vfm_icl_rx.sv
// Directed bench for vfm_icl_rx with a queue-based reference model checked every cycle.
module tb_vfm_icl_rx;

    localparam int DATA_W = 14;
    localparam int DEPTH  = 4;
    localparam int AW     = 2;

    logic              Clock_pin = 1'b0;
    logic              Resetn_pin;
    logic              req_b;
    logic [12:0]       req_hi;
    logic [DATA_W-1:0] link_req_in;
    logic [DATA_W-1:0] link_data_in;
    logic [DATA_W-1:0] link_ack_out;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              empty;
    logic              full;
    logic [AW:0]       count;
    logic [15:0]       rx_total;
    logic              proto_err;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: words held as a queue, handshake seen through a one-cycle input delay.
    logic              m_req_d  = 1'b0;
    logic [DATA_W-1:0] m_data_d = '0;
    logic [DATA_W-1:0] m_last   = '0;
    logic              m_ack    = 1'b0;
    logic              m_err    = 1'b0;
    logic [15:0]       m_total  = '0;
    logic              m_push;
    logic              m_pop;
    logic [DATA_W-1:0] q [$];

    assign link_req_in = {req_hi, req_b};

    vfm_icl_rx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) dut (
        .Clock_pin    (Clock_pin),
        .Resetn_pin   (Resetn_pin),
        .link_req_in  (link_req_in),
        .link_data_in (link_data_in),
        .link_ack_out (link_ack_out),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .rx_total     (rx_total),
        .proto_err    (proto_err)
    );

    always #5 Clock_pin = ~Clock_pin;

    always @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            m_req_d  = 1'b0;
            m_data_d = '0;
            m_ack    = 1'b0;
            m_err    = 1'b0;
            m_total  = '0;
            q.delete();
        end else begin
            m_push = !m_ack && m_req_d && (q.size() < DEPTH);
            m_pop  = rd_en && (q.size() > 0);
            if (m_ack && m_req_d && (m_data_d != m_last)) m_err = 1'b1;
            if (m_ack && !m_req_d) m_ack = 1'b0;
            if (m_pop) void'(q.pop_front());
            if (m_push) begin
                q.push_back(m_data_d);
                m_last  = m_data_d;
                m_ack   = 1'b1;
                m_total = m_total + 16'd1;
            end
            m_req_d  = link_req_in[0];
            m_data_d = link_data_in;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare every output against the model.
    task automatic tick();
        @(negedge Clock_pin);
        if (Resetn_pin) begin
            chk("m_ack",   32'(link_ack_out), 32'({13'b0, m_ack}));
            chk("m_rdata", 32'(rd_data), (q.size() == 0) ? 32'd0 : 32'(q[0]));
            chk("m_count", 32'(count), 32'(q.size()));
            chk("m_empty", 32'(empty), 32'(q.size() == 0));
            chk("m_full",  32'(full), 32'(q.size() == DEPTH));
            chk("m_total", 32'(rx_total), 32'(m_total));
            chk("m_perr",  32'(proto_err), 32'(m_err));
        end
    endtask

    task automatic wait_ack(input logic val, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (link_ack_out[0] === val) seen = 1'b1;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    task automatic send_word(input logic [DATA_W-1:0] d);
        link_data_in = d;
        req_b = 1'b1;
        wait_ack(1'b1, "ack_rise");
        req_b = 1'b0;
        wait_ack(1'b0, "ack_fall");
    endtask

    task automatic pop_expect(input logic [DATA_W-1:0] exp);
        chk("pop_head", 32'(rd_data), 32'(exp));
        chk("pop_nonempty", 32'(empty), 32'd0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic apply_reset();
        Resetn_pin = 1'b0;
        tick();
        tick();
        chk("rst_ack",   32'(link_ack_out), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full), 32'd0);
        chk("rst_total", 32'(rx_total), 32'd0);
        chk("rst_perr",  32'(proto_err), 32'd0);
        chk("rst_rdata", 32'(rd_data), 32'd0);
        Resetn_pin = 1'b1;
    endtask

    initial begin
        Resetn_pin   = 1'b0;
        req_b        = 1'b0;
        req_hi       = 13'h0AB5;
        link_data_in = '0;
        rd_en        = 1'b0;
        apply_reset();

        // Single word: latency of ack and data, then drop and pop.
        link_data_in = 14'h1A5;
        req_b = 1'b1;
        tick();
        chk("t1_ack_early", 32'(link_ack_out), 32'd0);
        chk("t1_empty_early", 32'(empty), 32'd1);
        tick();
        chk("t1_ack", 32'(link_ack_out), 32'd1);
        chk("t1_rdata", 32'(rd_data), 32'h1A5);
        chk("t1_empty", 32'(empty), 32'd0);
        chk("t1_count", 32'(count), 32'd1);
        chk("t1_total", 32'(rx_total), 32'd1);
        req_b = 1'b0;
        tick();
        chk("t1_ack_hold", 32'(link_ack_out), 32'd1);
        tick();
        chk("t1_ack_drop", 32'(link_ack_out), 32'd0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("t1_pop_empty", 32'(empty), 32'd1);
        chk("t1_pop_rdata", 32'(rd_data), 32'd0);

        // Fill and backpressure.
        apply_reset();
        for (int i = 1; i <= 4; i++) send_word(14'(i));
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd4);
        link_data_in = 14'h005;
        req_b = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("bp_ack_held", 32'(link_ack_out), 32'd0);
        chk("bp_head", 32'(rd_data), 32'h001);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("bp_pop_head", 32'(rd_data), 32'h002);
        chk("bp_pop_ack", 32'(link_ack_out), 32'd0);
        chk("bp_pop_count", 32'(count), 32'd3);
        tick();
        chk("bp_late_ack", 32'(link_ack_out), 32'd1);
        chk("bp_refill", 32'(count), 32'd4);
        req_b = 1'b0;
        wait_ack(1'b0, "bp_ack_fall");
        for (int i = 2; i <= 5; i++) pop_expect(14'(i));
        chk("bp_total", 32'(rx_total), 32'd5);

        // Pointer wrap with one word in flight at a time.
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            send_word(14'h100 + 14'(i));
            chk("wrap_count", 32'(count), 32'd1);
            pop_expect(14'h100 + 14'(i));
        end
        chk("wrap_total", 32'(rx_total), 32'd10);
        chk("wrap_empty", 32'(empty), 32'd1);

        // Simultaneous push and pop at count=2, then pop on empty.
        apply_reset();
        send_word(14'h201);
        send_word(14'h202);
        link_data_in = 14'h203;
        req_b = 1'b1;
        tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("pp_count", 32'(count), 32'd2);
        chk("pp_ack", 32'(link_ack_out), 32'd1);
        chk("pp_head", 32'(rd_data), 32'h202);
        req_b = 1'b0;
        wait_ack(1'b0, "pp_ack_fall");
        pop_expect(14'h202);
        pop_expect(14'h203);
        rd_en = 1'b1;
        tick();
        tick();
        rd_en = 1'b0;
        chk("pe_count", 32'(count), 32'd0);
        chk("pe_empty", 32'(empty), 32'd1);
        chk("pe_rdata", 32'(rd_data), 32'd0);

        // Protocol error: data changes while request is held.
        apply_reset();
        link_data_in = 14'h0AA;
        req_b = 1'b1;
        wait_ack(1'b1, "pe_ack_rise");
        link_data_in = 14'h0BB;
        tick();
        tick();
        chk("perr_set", 32'(proto_err), 32'd1);
        req_b = 1'b0;
        wait_ack(1'b0, "perr_ack_fall");
        chk("perr_fifo", 32'(rd_data), 32'h0AA);
        chk("perr_count", 32'(count), 32'd1);
        tick();
        tick();
        chk("perr_sticky", 32'(proto_err), 32'd1);
        pop_expect(14'h0AA);

        // Reset mid-handshake with three words held; request stays up across reset.
        apply_reset();
        send_word(14'h301);
        send_word(14'h302);
        link_data_in = 14'h303;
        req_b = 1'b1;
        wait_ack(1'b1, "mr_ack_rise");
        chk("mr_count_pre", 32'(count), 32'd3);
        #2;
        Resetn_pin = 1'b0;
        #1;
        chk("mr_ack_async", 32'(link_ack_out), 32'd0);
        chk("mr_count_async", 32'(count), 32'd0);
        chk("mr_empty_async", 32'(empty), 32'd1);
        chk("mr_perr_async", 32'(proto_err), 32'd0);
        link_data_in = 14'h077;
        tick();
        tick();
        Resetn_pin = 1'b1;
        tick();
        tick();
        chk("mr_recap_count", 32'(count), 32'd1);
        chk("mr_recap_ack", 32'(link_ack_out), 32'd1);
        chk("mr_recap_data", 32'(rd_data), 32'h077);
        chk("mr_recap_total", 32'(rx_total), 32'd1);
        req_b = 1'b0;
        wait_ack(1'b0, "mr_ack_fall");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
